// File: rtl/bcd_digit_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// bcd_seq_pkg
// Shared types and constants for the BCD digit sequencer.
//   state_e  : sequencer control state (IDLE, RUN, PAUSE)
//   BCD_MAX  : largest legal BCD digit (9)
//   BCD_MIN  : smallest legal BCD digit (0)
//   is_bcd() : true when a 4-bit code is a legal BCD digit
// ----------------------------------------------------------------------------
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [3:0] code);
    return code <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sequencer_if.sv
// ----------------------------------------------------------------------------
// bcd_digit_sequencer_if
// Control and status bundle of the BCD digit sequencer.
//   Controls (master -> slave): start, stop, clear, dir, load, load_val,
//                               prescale
//   Status   (slave -> master): digit, running, carry, borrow, load_err
// The sequencer itself connects through the slave modport.
// ----------------------------------------------------------------------------
interface bcd_digit_sequencer_if #(
  parameter int PRESCALE_W = 16
);

  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  dir;
  logic                  load;
  logic [3:0]            load_val;
  logic [PRESCALE_W-1:0] prescale;

  logic [3:0]            digit;
  logic                  running;
  logic                  carry;
  logic                  borrow;
  logic                  load_err;

  modport master (
    output start, stop, clear, dir, load, load_val, prescale,
    input  digit, running, carry, borrow, load_err
  );

  modport slave (
    input  start, stop, clear, dir, load, load_val, prescale,
    output digit, running, carry, borrow, load_err
  );

endinterface

// File: rtl/bcd_tick_gen.sv
// ----------------------------------------------------------------------------
// bcd_tick_gen
// Prescaler for the digit sequencer. Counts enabled cycles and raises tick
// on the cycle in which the counter has reached the programmed period.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : count this cycle (sequencer running and not preempted)
//   clr      : synchronous counter clear, dominates en
//   prescale : step period minus one, in cycles
//   tick     : high in the cycle where a step is due (only while en)
// ----------------------------------------------------------------------------
module bcd_tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_due;

  // >= rather than == so that lowering prescale below the current count
  // produces a step on the next enabled cycle instead of a long wrap.
  assign w_due = (r_cnt >= prescale);
  assign tick  = en && w_due;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      // Cannot overflow: the counter restarts at or before prescale.
      r_cnt <= w_due ? '0 : r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// ----------------------------------------------------------------------------
// bcd_digit_sequencer
// Programmable-rate BCD counter feeding the BCD-to-Gray stage. Counts 0..9
// up or down once per (prescale + 1) running cycles, with run/pause control,
// synchronous clear and load, and one-cycle wrap/error pulses. The digit
// register can only ever hold 0..9: illegal load values are rejected.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : control/status bundle (slave side)
//         start/stop   run control (stop wins when both are high)
//         clear        digit := 0, state := IDLE, counter := 0
//         dir          1 = up, 0 = down
//         load/load_val synchronous load of a BCD value
//         prescale     step period minus one
//         digit        current BCD digit (registered)
//         running      high while in RUN (registered)
//         carry/borrow one-cycle wrap pulses aligned with the new digit
//         load_err     one-cycle pulse on a load of a value above 9
// ----------------------------------------------------------------------------
module bcd_digit_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_digit_sequencer_if.slave  bus
);

  state_e     r_state;
  state_e     w_state_nxt;

  logic [3:0] r_digit;
  logic       r_running;
  logic       r_carry;
  logic       r_borrow;
  logic       r_load_err;

  logic [3:0] w_digit_nxt;
  logic       w_carry_nxt;
  logic       w_borrow_nxt;
  logic       w_load_err_nxt;

  logic       w_load_ok;
  logic       w_idle_start;
  logic       w_cnt_en;
  logic       w_cnt_clr;
  logic       w_tick;

  assign w_load_ok    = bus.load && is_bcd(bus.load_val);
  assign w_idle_start = (r_state == IDLE) && bus.start && !bus.stop;

  // The prescaler advances only in RUN cycles that are not preempted. A
  // stop freezes it on the sampling edge; any load (legal or not) and clear
  // outrank the step, so the counter does not move in those cycles either.
  assign w_cnt_en  = (r_state == RUN) && !bus.stop && !bus.load && !bus.clear;
  assign w_cnt_clr = bus.clear || w_load_ok || w_idle_start;

  bcd_tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (w_cnt_en),
    .clr      (w_cnt_clr),
    .prescale (bus.prescale),
    .tick     (w_tick)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_digit_nxt    = r_digit;
    w_carry_nxt    = 1'b0;
    w_borrow_nxt   = 1'b0;
    w_load_err_nxt = 1'b0;

    unique case (r_state)
      IDLE:    if (bus.start && !bus.stop) w_state_nxt = RUN;
      RUN:     if (bus.stop)               w_state_nxt = PAUSE;
      PAUSE:   if (bus.start && !bus.stop) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase

    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_digit_nxt = BCD_MIN;
    end else if (bus.load) begin
      if (w_load_ok) begin
        w_digit_nxt = bus.load_val;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (w_tick) begin
      if (bus.dir) begin
        if (r_digit == BCD_MAX) begin
          w_digit_nxt = BCD_MIN;
          w_carry_nxt = 1'b1;
        end else begin
          w_digit_nxt = r_digit + 4'd1;
        end
      end else begin
        if (r_digit == BCD_MIN) begin
          w_digit_nxt  = BCD_MAX;
          w_borrow_nxt = 1'b1;
        end else begin
          w_digit_nxt = r_digit - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every register here is reset, so status outputs are defined the
  // instant rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit    <= BCD_MIN;
      r_running  <= 1'b0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_digit    <= w_digit_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_carry    <= w_carry_nxt;
      r_borrow   <= w_borrow_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign bus.digit    = r_digit;
  assign bus.running  = r_running;
  assign bus.carry    = r_carry;
  assign bus.borrow   = r_borrow;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bcd_digit_sequencer
// Directed scenarios with spec-derived constants, then a randomized run
// compared against a cycle-level behavioural model of the sequencer.
// Inputs change on the falling edge; outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_bcd_digit_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_digit_sequencer_if #(.PRESCALE_W(16)) bus ();

  bcd_digit_sequencer #(.PRESCALE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state: plain integers and flags.
  int m_digit;
  int m_cnt;
  bit m_run;
  bit m_paused;
  bit m_carry;
  bit m_borrow;
  bit m_err;

  task automatic next_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.clear    = 1'b0;
    bus.dir      = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.prescale = 16'd0;
  endtask

  // Returns the block to IDLE with digit 0 (driving only).
  task automatic stop_and_clear();
    bus.stop = 1'b1;
    next_edge();
    bus.stop  = 1'b0;
    bus.clear = 1'b1;
    next_edge();
    bus.clear = 1'b0;
  endtask

  task automatic model_reset();
    m_digit  = 0;
    m_cnt    = 0;
    m_run    = 0;
    m_paused = 0;
    m_carry  = 0;
    m_borrow = 0;
    m_err    = 0;
  endtask

  // Advances the model by one clock edge using the inputs now on the bus.
  task automatic model_update();
    bit was_run;
    bit stepping;
    was_run  = m_run;
    stepping = 0;
    m_carry  = 0;
    m_borrow = 0;
    m_err    = 0;
    if (bus.clear) begin
      m_digit  = 0;
      m_cnt    = 0;
      m_run    = 0;
      m_paused = 0;
    end else begin
      if (bus.load) begin
        if (int'(bus.load_val) <= 9) begin
          m_digit = int'(bus.load_val);
          m_cnt   = 0;
        end else begin
          m_err = 1;
        end
      end else if (was_run && !bus.stop) begin
        if (m_cnt >= int'(bus.prescale)) begin
          m_cnt    = 0;
          stepping = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (stepping) begin
        if (bus.dir) begin
          m_carry = (m_digit == 9);
          m_digit = (m_digit + 1) % 10;
        end else begin
          m_borrow = (m_digit == 0);
          m_digit  = (m_digit + 9) % 10;
        end
      end
      if (was_run) begin
        if (bus.stop) begin
          m_run    = 0;
          m_paused = 1;
        end
      end else if (bus.start && !bus.stop) begin
        if (!m_paused) m_cnt = 0;
        m_run    = 1;
        m_paused = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_tests++;
    if ({bus.digit, bus.running, bus.carry, bus.borrow, bus.load_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got digit=%0d run=%b c=%b b=%b err=%b, want all 0",
               bus.digit, bus.running, bus.carry, bus.borrow, bus.load_err);
    end
    @(negedge clk);
    rst = 1'b0;
    next_edge();
    n_tests++;
    if (bus.running !== 1'b0 || bus.digit !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got run=%b digit=%0d, want run=0 digit=0",
               bus.running, bus.digit);
    end
  endtask

  task automatic test_count_up();
    bus.prescale = 16'd0;
    bus.dir      = 1'b1;
    bus.start    = 1'b1;
    next_edge();
    bus.start = 1'b0;
    n_tests++;
    if (bus.running !== 1'b1 || bus.digit !== 4'd0) begin
      n_fail++;
      $display("FAIL up_start: got run=%b digit=%0d, want run=1 digit=0",
               bus.running, bus.digit);
    end
    for (int i = 1; i <= 10; i++) begin
      next_edge();
      n_tests++;
      if (bus.digit !== 4'(i % 10) || bus.carry !== (i == 10)) begin
        n_fail++;
        $display("FAIL up_step%0d: got digit=%0d carry=%b, want digit=%0d carry=%b",
                 i, bus.digit, bus.carry, i % 10, (i == 10));
      end
    end
    stop_and_clear();
  endtask

  task automatic test_count_down();
    int exp_d;
    bus.prescale = 16'd3;
    bus.dir      = 1'b0;
    bus.start    = 1'b1;
    next_edge();
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      next_edge();
      exp_d = (i < 4) ? 0 : (i < 8) ? 9 : 8;
      n_tests++;
      if (bus.digit !== 4'(exp_d) || bus.borrow !== (i == 4)) begin
        n_fail++;
        $display("FAIL down_edge%0d: got digit=%0d borrow=%b, want digit=%0d borrow=%b",
                 i, bus.digit, bus.borrow, exp_d, (i == 4));
      end
    end
    stop_and_clear();
  endtask

  task automatic test_pause_resume();
    bus.prescale = 16'd4;
    bus.dir      = 1'b1;
    bus.start    = 1'b1;
    next_edge();
    bus.start = 1'b0;
    next_edge();
    next_edge();
    bus.stop = 1'b1;
    next_edge();
    bus.stop = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) next_edge();
      n_tests++;
      if (bus.running !== 1'b0 || bus.digit !== 4'd0) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got run=%b digit=%0d, want run=0 digit=0",
                 i, bus.running, bus.digit);
      end
    end
    bus.start = 1'b1;
    next_edge();
    bus.start = 1'b0;
    n_tests++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_run: got run=%b, want run=1", bus.running);
    end
    for (int i = 1; i <= 3; i++) begin
      next_edge();
      n_tests++;
      if (bus.digit !== 4'((i == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL resume_edge%0d: got digit=%0d, want %0d",
                 i, bus.digit, (i == 3) ? 1 : 0);
      end
    end
    stop_and_clear();
  endtask

  task automatic test_load();
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    next_edge();
    n_tests++;
    if (bus.digit !== 4'd7 || bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_7: got digit=%0d err=%b, want digit=7 err=0",
               bus.digit, bus.load_err);
    end
    bus.load_val = 4'd12;
    next_edge();
    bus.load = 1'b0;
    n_tests++;
    if (bus.digit !== 4'd7 || bus.load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL load_12: got digit=%0d err=%b, want digit=7 err=1",
               bus.digit, bus.load_err);
    end
    next_edge();
    n_tests++;
    if (bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_err_once: got err=%b, want 0", bus.load_err);
    end
    // Load over a wrapping step: digit 9 running at prescale 0.
    bus.load     = 1'b1;
    bus.load_val = 4'd9;
    next_edge();
    bus.load     = 1'b0;
    bus.prescale = 16'd0;
    bus.dir      = 1'b1;
    bus.start    = 1'b1;
    next_edge();
    bus.start    = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd4;
    next_edge();
    bus.load = 1'b0;
    n_tests++;
    if (bus.digit !== 4'd4 || bus.carry !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_wrap: got digit=%0d carry=%b, want digit=4 carry=0",
               bus.digit, bus.carry);
    end
    next_edge();
    n_tests++;
    if (bus.digit !== 4'd5) begin
      n_fail++;
      $display("FAIL step_after_load: got digit=%0d, want 5", bus.digit);
    end
    stop_and_clear();
  endtask

  task automatic test_start_stop_clear();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    next_edge();
    bus.stop = 1'b0;
    n_tests++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle: got run=%b, want 0", bus.running);
    end
    bus.prescale = 16'd0;
    bus.dir      = 1'b1;
    next_edge();
    bus.start = 1'b0;
    next_edge();
    next_edge();
    bus.start = 1'b1;
    bus.clear = 1'b1;
    next_edge();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    n_tests++;
    if (bus.running !== 1'b0 || bus.digit !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_with_start: got run=%b digit=%0d, want run=0 digit=0",
               bus.running, bus.digit);
    end
  endtask

  task automatic test_async_reset();
    bus.prescale = 16'd0;
    bus.dir      = 1'b1;
    bus.start    = 1'b1;
    next_edge();
    bus.start = 1'b0;
    next_edge();
    next_edge();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.digit, bus.running, bus.carry, bus.borrow, bus.load_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got digit=%0d run=%b c=%b b=%b err=%b, want all 0",
               bus.digit, bus.running, bus.carry, bus.borrow, bus.load_err);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      next_edge();
      n_tests++;
      if (bus.running !== 1'b0 || bus.digit !== 4'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle%0d: got run=%b digit=%0d, want run=0 digit=0",
                 i, bus.running, bus.digit);
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.stop     = ($urandom_range(0, 7) == 0);
      bus.clear    = ($urandom_range(0, 60) == 0);
      bus.load     = ($urandom_range(0, 15) == 0);
      bus.load_val = 4'($urandom_range(0, 15));
      bus.dir      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) bus.prescale = 16'($urandom_range(0, 5));
      model_update();
      next_edge();
      n_tests++;
      if (bus.digit > 4'd9 ||
          {bus.digit, bus.running, bus.carry, bus.borrow, bus.load_err} !==
          {4'(m_digit), m_run, m_carry, m_borrow, m_err}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got d=%0d r=%b c=%b b=%b e=%b, want d=%0d r=%b c=%b b=%b e=%b",
                 i, bus.digit, bus.running, bus.carry, bus.borrow, bus.load_err,
                 m_digit, m_run, m_carry, m_borrow, m_err);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_count_up();
    test_count_down();
    test_pause_resume();
    test_load();
    test_start_stop_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_digit_sequencer.md
# bcd_digit_sequencer

Programmable-rate BCD digit sequencer that produces the 4-bit BCD digit feeding the BCD-to-Gray converter stage directly downstream. It counts 0–9 up or down at a rate set by a prescaler, supports run/pause control and synchronous load, and flags wrap events. The digit output must always be legal BCD (0–9); the converter drives `zzzz` on codes 10–15, so no illegal code may ever reach it.

## Interface
- `PRESCALE_W`, 16: width of the prescale value and of the internal cycle counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level, sampled each cycle; moves IDLE/PAUSE → RUN.
- `stop`  in  1  level, sampled each cycle; moves RUN → PAUSE.
- `clear`  in  1  synchronous; digit := 0, state := IDLE.
- `dir`  in  1  1 = count up, 0 = count down; sampled at each step.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  4  BCD value to load; 10–15 illegal.
- `prescale`  in  PRESCALE_W  step period minus one, in cycles.
- `digit`  out  4  current BCD digit, always 0–9.
- `running`  out  1  high while state = RUN.
- `carry`  out  1  one-cycle pulse on up-wrap 9 → 0.
- `borrow`  out  1  one-cycle pulse on down-wrap 0 → 9.
- `load_err`  out  1  one-cycle pulse when `load` is asserted with `load_val` > 9.

## Operation
- States: IDLE, RUN, PAUSE.
  - IDLE → RUN on `start`; the cycle counter is cleared to 0.
  - RUN → PAUSE on `stop`; the cycle counter holds.
  - PAUSE → RUN on `start`; the cycle counter resumes from its held value.
  - `stop` in IDLE or PAUSE is ignored.
  - `start` and `stop` together: `stop` wins. In RUN this means PAUSE; in IDLE or PAUSE the state holds.
- Prescaler, active only in RUN:
  - If `cnt >= prescale`: `cnt := 0` and the digit steps.
  - Otherwise: `cnt := cnt + 1`.
  - `prescale` = 0 therefore steps the digit every cycle.
  - Lowering `prescale` below the current `cnt` causes a step on the next RUN cycle.
- Step:
  - Up: digit + 1; 9 → 0 with `carry`.
  - Down: digit − 1; 0 → 9 with `borrow`.
- Load:
  - Legal `load_val`: digit := `load_val` in any state, and `cnt` := 0.
  - Illegal `load_val`: ignored (digit and `cnt` unchanged), `load_err` pulses.
  - The state is not changed by `load`.
- Priority within one cycle: `clear` > `load` > step.
  - A suppressed step produces no `carry`/`borrow` pulse.
  - `clear` also zeroes `cnt`, and it overrides `start`.
- Arithmetic: `digit` is held in 4 bits and compared only against 0 and 9. The `cnt` increment never wraps, because `cnt` resets at or before `prescale` ≤ 2^PRESCALE_W − 1.

## Timing
- Reset values (immediate on `rst` assertion, independent of `clk`): `digit` = 0, `running` = 0, `carry` = 0, `borrow` = 0, `load_err` = 0, state = IDLE, `cnt` = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Start latency: `start` sampled at edge k → `running` = 1 after edge k. The first step lands at edge k + 1 + `prescale`, with `digit` updated after that edge.
- Step period in steady RUN: `prescale` + 1 cycles.
- `carry`/`borrow` are high for exactly the cycle following the wrapping edge, aligned with the new `digit` value.
- `load` and `clear` take effect after the sampling edge; `load_err` is aligned the same way.
- Reset asserted mid-RUN: everything returns to reset values asynchronously. After deassertion the block stays in IDLE until `start`.

## Structure
- Shared package `bcd_seq_pkg`:
  - state enum {IDLE, RUN, PAUSE}.
  - constants `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0.
- Sub-module `bcd_tick_gen`:
  - Holds the prescaler counter.
  - Inputs: `en`, `clr`, `prescale`.
  - Output: one-cycle `tick`.
- Top level holds the FSM, the digit register, and the wrap/load logic.

## Test plan
- Reset, then `prescale` = 0, `dir` = 1, `start` pulse → `digit` 0,1,…,9,0 on consecutive cycles; `carry` high only with the second 0.
- `prescale` = 3, `dir` = 0, `start` at edge k → `digit` 0→9 at edge k+4 with `borrow`, then 8 at edge k+8.
- RUN with `prescale` = 4: `stop` at `cnt` = 2, hold 10 cycles, `start` → next step 3 cycles after resume, `digit` unchanged during PAUSE.
- `load` with `load_val` = 7 → `digit` = 7. `load` with `load_val` = 12 → `digit` stays 7 and `load_err` pulses once. `load` in the same cycle as a wrapping step → `digit` = `load_val`, no `carry`.
- `start` with `stop` in IDLE → stays IDLE. `clear` with `start` → IDLE, `digit` 0.
- `rst` pulse mid-RUN between edges → outputs at reset values immediately; no activity until the next `start`.
- Scoreboard: `digit` is never > 9 across 10k random cycles of all inputs.
